// File: rtl/multicycle_pc_sequencer_pkg.sv
// Shared state encoding and opcode constants for the multi-cycle PC sequencer.
package multicycle_pc_sequencer_pkg;

    typedef enum logic [2:0] {
        STATE_IF   = 3'd0,
        STATE_ID   = 3'd1,
        STATE_EX   = 3'd2,
        STATE_MEM  = 3'd3,
        STATE_WB   = 3'd4,
        STATE_HALT = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_ADDIU) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/multicycle_pc_sequencer_pc_next_calc.sv
// Combinational next-PC: sequential increment or branch target, plus end-of-program detect.
module pc_next_calc
    import multicycle_pc_sequencer_pkg::*;
#(
    parameter int          PC_W     = 32,
    parameter int unsigned PROG_LEN = 11
) (
    input  logic [PC_W-1:0] PC,
    input  logic [15:0]     imm,
    input  logic            branch,
    input  logic            zero,
    input  logic [5:0]      opcode,
    output logic [PC_W-1:0] next_pc,
    output logic            end_of_prog
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] imm_sext;
    logic            taken;

    always_comb begin
        pc_inc   = PC + PC_W'(1);
        imm_sext = {{(PC_W-16){imm[15]}}, imm};
        // Target arithmetic wraps modulo 2^PC_W; only the unsigned bound check ends the program.
        taken    = branch && (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero));
        next_pc  = taken ? (pc_inc + imm_sext) : pc_inc;
        end_of_prog = (next_pc >= PC_W'(PROG_LEN));
    end

endmodule

// File: rtl/multicycle_pc_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer owning the PC, retire counter and HALT state.
// Optional macro PC_SEQ_MEM_HANDSHAKE_EN: MEM holds until mem_ready=1 (else one cycle).
module multicycle_pc_sequencer
    import multicycle_pc_sequencer_pkg::*;
#(
    parameter int          PC_W     = 32,
    parameter int unsigned PROG_LEN = 11,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [15:0]      immediate_value,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic [PC_W-1:0]  PC,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q;
    logic             illegal_op_q;
    logic             is_lw_q;

    logic [PC_W-1:0]  next_pc;
    logic             end_of_prog;
    logic             mem_done;
    logic             retire;

`ifdef PC_SEQ_MEM_HANDSHAKE_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    pc_next_calc #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) u_pc_next_calc (
        .PC          (pc_q),
        .imm         (immediate_value),
        .branch      (state_q == STATE_EX),
        .zero        (alu_zero),
        .opcode      (opcode),
        .next_pc     (next_pc),
        .end_of_prog (end_of_prog)
    );

    // An instruction retires on the edge that leaves its last state; this is the only PC update point.
    always_comb begin
        retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
        retire    = 1'b0;
        case (state_q)
            STATE_ID:  retire = !is_known_op(opcode);
            STATE_EX:  retire = !((opcode == OP_LW) || (opcode == OP_SW) ||
                                  (opcode == OP_RTYPE) || (opcode == OP_ADDIU));
            STATE_MEM: retire = mem_done && !is_lw_q;
            STATE_WB:  retire = 1'b1;
            default:   retire = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STATE_IF;
            pc_q         <= '0;
            retired_q    <= '0;
            halted_q     <= 1'b0;
            illegal_op_q <= 1'b0;
            is_lw_q      <= 1'b0;
        end else begin
            illegal_op_q <= 1'b0;
            if (retire) begin
                pc_q         <= next_pc;
                retired_q    <= retired_d;
                halted_q     <= end_of_prog;
                state_q      <= end_of_prog ? STATE_HALT : STATE_IF;
                illegal_op_q <= (state_q == STATE_ID);
            end else begin
                case (state_q)
                    STATE_IF: state_q <= STATE_ID;
                    STATE_ID: state_q <= STATE_EX;
                    STATE_EX: begin
                        is_lw_q <= (opcode == OP_LW);
                        state_q <= ((opcode == OP_LW) || (opcode == OP_SW)) ? STATE_MEM : STATE_WB;
                    end
                    STATE_MEM: if (mem_done) state_q <= STATE_WB;
                    default:   state_q <= state_q;
                endcase
            end
        end
    end

    assign state      = state_q;
    assign PC         = pc_q;
    assign halted     = halted_q;
    assign illegal_op = illegal_op_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_pc_sequencer.sv
// Self-checking bench: directed vector table, reset/saturation sequences, random instructions vs model.
module tb_multicycle_pc_sequencer;
    import multicycle_pc_sequencer_pkg::*;

    localparam int PC_W     = 32;
    localparam int PROG_LEN = 11;
    localparam int CNT_W    = 4;
    localparam int RET_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [15:0]      immediate_value;
    logic             alu_zero;
    logic             mem_ready;
    logic [2:0]       state;
    logic [PC_W-1:0]  PC;
    logic             halted;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;

    multicycle_pc_sequencer #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .immediate_value (immediate_value),
        .alu_zero        (alu_zero),
        .mem_ready       (mem_ready),
        .state           (state),
        .PC              (PC),
        .halted          (halted),
        .illegal_op      (illegal_op),
        .retired         (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_pc;
    int          m_ret;
    bit          m_halt;

    typedef struct {
        bit          rst;
        logic [5:0]  op;
        logic [15:0] imm;
        bit          zero;
        int          wait_n;
        logic [31:0] exp_pc;
        int          exp_ret;
        bit          exp_halt;
        bit          exp_ill;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit known_op(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
               op == OP_ADDIU || op == OP_BEQ || op == OP_BNE;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        opcode = '0; immediate_value = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        #1;
        check("rst state", state, 3'd0);
        check("rst PC", PC, 0);
        check("rst retired", retired, 0);
        check("rst halted", halted, 0);
        check("rst illegal", illegal_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 0; m_ret = 0; m_halt = 1'b0;
    endtask

    // Runs one instruction from its IF cycle; expected state trace and outcome come from the ISA rules.
    task automatic run_instr(input logic [5:0] op, input logic [15:0] imm, input bit zero,
                             input int wait_n, input string tag, output logic ill_seen);
        int          seq[$];
        int          mem_cycles;
        int          mem_idx;
        bit          taken;
        logic [31:0] nxt;
`ifdef PC_SEQ_MEM_HANDSHAKE_EN
        mem_cycles = wait_n + 1;
`else
        mem_cycles = 1;
`endif
        seq = {};
        seq.push_back(0);
        seq.push_back(1);
        if (known_op(op)) begin
            seq.push_back(2);
            if (op == OP_LW || op == OP_SW)
                for (int i = 0; i < mem_cycles; i++) seq.push_back(3);
            if (op == OP_LW || op == OP_RTYPE || op == OP_ADDIU) seq.push_back(4);
        end
        opcode = op; immediate_value = imm; alu_zero = zero;
        mem_idx = 0;
        for (int k = 0; k < seq.size(); k++) begin
            check($sformatf("%s state[%0d]", tag, k), state, seq[k]);
            if (k > 0) check($sformatf("%s illegal[%0d]", tag, k), illegal_op, 0);
            if (seq[k] == 3) begin
                mem_ready = (mem_idx >= wait_n);
                mem_idx++;
            end else begin
                mem_ready = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end
        taken = (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
        nxt = taken ? (m_pc + 32'd1 + {{16{imm[15]}}, imm}) : (m_pc + 32'd1);
        m_pc = nxt;
        m_ret = (m_ret < RET_MAX) ? m_ret + 1 : RET_MAX;
        m_halt = (nxt >= 32'(PROG_LEN));
        check({tag, " end state"}, state, m_halt ? 3'd5 : 3'd0);
        check({tag, " PC"}, PC, m_pc);
        check({tag, " retired"}, retired, m_ret);
        check({tag, " halted"}, halted, m_halt);
        check({tag, " illegal"}, illegal_op, !known_op(op));
        ill_seen = illegal_op;
        if (m_halt) begin
            for (int h = 0; h < 3; h++) begin
                opcode = 6'($urandom); immediate_value = 16'($urandom);
                alu_zero = 1'($urandom); mem_ready = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
                check({tag, " hold state"}, state, 3'd5);
                check({tag, " hold PC"}, PC, m_pc);
                check({tag, " hold retired"}, retired, m_ret);
                check({tag, " hold halted"}, halted, 1);
                check({tag, " hold illegal"}, illegal_op, 0);
            end
        end
    endtask

    initial begin
        logic        ill;
        logic [5:0]  rop;
        logic [15:0] rimm;

        rst_n = 1'b0;
        opcode = '0; immediate_value = '0; alu_zero = 1'b0; mem_ready = 1'b0;

        //          rst  op        imm       z  wait exp_pc         ret halt ill
        vecs[0]  = '{1, OP_LW,    16'h0000, 0, 0, 32'd1,          1, 0, 0};
        vecs[1]  = '{0, OP_SW,    16'h0000, 0, 2, 32'd2,          2, 0, 0};
        vecs[2]  = '{0, OP_RTYPE, 16'h0000, 0, 0, 32'd3,          3, 0, 0};
        vecs[3]  = '{0, 6'h3F,    16'h0000, 0, 0, 32'd4,          4, 0, 1};
        vecs[4]  = '{0, OP_ADDIU, 16'h0000, 0, 0, 32'd5,          5, 0, 0};
        vecs[5]  = '{0, OP_BEQ,   16'h0005, 0, 0, 32'd6,          6, 0, 0};
        vecs[6]  = '{0, OP_BEQ,   16'h0005, 1, 0, 32'd12,         7, 1, 0};
        vecs[7]  = '{1, OP_BEQ,   16'h0009, 1, 0, 32'd10,         1, 0, 0};
        vecs[8]  = '{0, OP_BNE,   16'hFFFD, 0, 0, 32'd8,          2, 0, 0};
        vecs[9]  = '{0, OP_RTYPE, 16'h0000, 0, 0, 32'd9,          3, 0, 0};
        vecs[10] = '{0, OP_LW,    16'h0000, 0, 3, 32'd10,         4, 0, 0};
        vecs[11] = '{0, OP_BNE,   16'hFFFD, 1, 0, 32'd11,         5, 1, 0};
        vecs[12] = '{1, OP_BEQ,   16'hFFFF, 1, 0, 32'd0,          1, 0, 0};
        vecs[13] = '{0, OP_BNE,   16'h0009, 0, 0, 32'd10,         2, 0, 0};
        vecs[14] = '{0, 6'h3F,    16'h0000, 0, 0, 32'd11,         3, 1, 1};
        vecs[15] = '{1, OP_BEQ,   16'h8000, 1, 0, 32'hFFFF8001,   1, 1, 0};
        vecs[16] = '{1, OP_RTYPE, 16'h0000, 0, 0, 32'd1,          1, 0, 0};

        for (int v = 0; v < 17; v++) begin
            if (vecs[v].rst) do_reset();
            run_instr(vecs[v].op, vecs[v].imm, vecs[v].zero, vecs[v].wait_n,
                      $sformatf("vec%0d", v), ill);
            check($sformatf("vec%0d tbl PC", v), PC, vecs[v].exp_pc);
            check($sformatf("vec%0d tbl retired", v), retired, vecs[v].exp_ret);
            check($sformatf("vec%0d tbl halted", v), halted, vecs[v].exp_halt);
            check($sformatf("vec%0d tbl illegal", v), ill, vecs[v].exp_ill);
        end

        // Reset asserted in the middle of EX must abort at once.
        do_reset();
        run_instr(OP_RTYPE, 16'h0000, 1'b0, 0, "pre_abort", ill);
        opcode = OP_LW;
        check("abort IF", state, 3'd0);
        @(posedge clk); @(negedge clk);
        check("abort ID", state, 3'd1);
        @(posedge clk); @(negedge clk);
        check("abort EX", state, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("abort state", state, 3'd0);
        check("abort PC", PC, 0);
        check("abort retired", retired, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 0; m_ret = 0; m_halt = 1'b0;
        run_instr(OP_LW, 16'h0000, 1'b0, 1, "post_abort", ill);

        // Branch-to-self loop drives the retire counter into saturation.
        do_reset();
        for (int s = 0; s < RET_MAX + 3; s++) run_instr(OP_BEQ, 16'hFFFF, 1'b1, 0, "selfloop", ill);
        check("sat retired", retired, RET_MAX);
        check("sat PC", PC, 0);

        do_reset();
        for (int r = 0; r < 80; r++) begin
            case ($urandom_range(0, 7))
                0: rop = OP_RTYPE;
                1: rop = OP_LW;
                2: rop = OP_SW;
                3: rop = OP_ADDIU;
                4, 7: rop = OP_BEQ;
                5: rop = OP_BNE;
                default: begin
                    rop = 6'($urandom);
                    if (known_op(rop)) rop = 6'h3F;
                end
            endcase
            rimm = 16'($urandom_range(0, 8)) - 16'd4;
            run_instr(rop, rimm, 1'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", r), ill);
            if (m_halt) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
